// File: rtl/hc595_ctrl_if.sv
// hc595_ctrl_if: pin bundle between the seven-segment scanner, the 74HC595
// serialiser and the shift-register chain.
//   sel[5:0]   digit select from the scanner (bit n drives digit n)
//   seg[7:0]   segment pattern from the scanner (bit 7 is the DP)
//   ds         serial data to the 595 DS pin
//   shcp       shift clock to the 595 SHCP pin
//   stcp       storage latch clock to the 595 STCP pin
//   oe         active-low output enable to the 595 OE pin
//   frame_done one-cycle pulse per completed latch
// There is no valid/ready handshake: sel/seg are level signals sampled once
// per frame, and every output is a free-running registered pin.
interface hc595_ctrl_if;
  logic [5:0] sel;
  logic [7:0] seg;
  logic       ds;
  logic       shcp;
  logic       stcp;
  logic       oe;
  logic       frame_done;

  // master: the side that supplies the scanner data and watches the pins
  modport master (
    output sel, seg,
    input  ds, shcp, stcp, oe, frame_done
  );

  // slave: the serialiser itself
  modport slave (
    input  sel, seg,
    output ds, shcp, stcp, oe, frame_done
  );
endinterface

// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises the scanner's {seg, sel} pair into two daisy-chained
// 74HC595s. Each frame is 15 slots of 2*CLK_DIV cycles: slots 0..13 shift one
// bit (LSB of {seg, sel} first) with shcp rising mid-slot, slot 14 pulses
// stcp in its second half. Frames repeat back-to-back.
// Ports:
//   sys_clk  system clock
//   sys_rst  asynchronous active-high reset
//   bus      hc595_ctrl_if.slave (sel/seg in, ds/shcp/stcp/oe/frame_done out)
// Parameter:
//   CLK_DIV  sys_clk cycles per shcp half-period, 1..8
module hc595_ctrl #(
  parameter int CLK_DIV = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  hc595_ctrl_if.slave bus
);

  localparam int PW = (2 * CLK_DIV > 2) ? $clog2(2 * CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(2 * CLK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_DIV);
  localparam logic [3:0]    S_LATCH = 4'd14;

  logic [PW-1:0] p, p_n;
  logic [3:0]    s, s_n;
  logic [13:0]   shadow, shadow_n;
  logic          run;
  logic          frame_end;
  logic          hi_half;
  logic          latch_slot;
  logic          ds_n;

  logic ds_q, shcp_q, stcp_q, oe_q, frame_done_q;

  // Next-state of the counters and the shadow word. The first edge after
  // reset release only captures the inputs and parks the counters at (0,0),
  // so cycle 0 already presents F[0].
  always_comb begin
    p_n       = p;
    s_n       = s;
    shadow_n  = shadow;
    frame_end = 1'b0;
    if (!run) begin
      p_n      = '0;
      s_n      = '0;
      shadow_n = {bus.seg, bus.sel};
    end else if (p == P_LAST) begin
      p_n = '0;
      if (s == S_LATCH) begin
        s_n       = '0;
        shadow_n  = {bus.seg, bus.sel};
        frame_end = 1'b1;
      end else begin
        s_n = s + 4'd1;
      end
    end else begin
      p_n = p + 1'b1;
    end
  end

  // Pins are decoded from the next state so they line up with the counters
  // in the same cycle while still coming straight out of flops.
  always_comb begin
    hi_half    = (p_n >= P_HALF);
    latch_slot = (s_n == S_LATCH);
    ds_n       = 1'b0;
    if (!latch_slot) begin
      ds_n = shadow_n[s_n];
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      p            <= '0;
      s            <= '0;
      shadow       <= '0;
      run          <= 1'b0;
      ds_q         <= 1'b0;
      shcp_q       <= 1'b0;
      stcp_q       <= 1'b0;
      frame_done_q <= 1'b0;
      oe_q         <= 1'b1;
    end else begin
      p            <= p_n;
      s            <= s_n;
      shadow       <= shadow_n;
      run          <= 1'b1;
      ds_q         <= ds_n;
      shcp_q       <= hi_half & ~latch_slot;
      stcp_q       <= hi_half & latch_slot;
      frame_done_q <= latch_slot && (p_n == P_HALF);
      // Display stays blanked until the first fully shifted frame has been
      // latched, hiding whatever the 595s powered up with.
      if (frame_end) begin
        oe_q <= 1'b0;
      end
    end
  end

  assign bus.ds         = ds_q;
  assign bus.shcp       = shcp_q;
  assign bus.stcp       = stcp_q;
  assign bus.oe         = oe_q;
  assign bus.frame_done = frame_done_q;

endmodule
